dmac_write_burst: RTL and testbench

Parametrised AXI4 write engine for the DMA controller; next generation of the single-burst DMA write path. Takes a destination address and a total beat count, splits the transfer into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and streams write data from the DMA data FIFO. It sits between the DMA channel control and the AXI interconnect master port. It reports completion and the AXI write response status.

---
 rtl/dmac_write_burst_if.sv | 41 ++++
 rtl/dmac_write_burst.sv | 170 +++++++++++++++++
 tb/tb_dmac_write_burst.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_write_burst_if.sv
// rtl/dmac_write_burst_if.sv - AXI4 write-channel bundle (AW, W, B) between the DMA write engine and the interconnect
interface dmac_write_burst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = 4
);
  logic [ID_BITS-1:0]      m_awid;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [7:0]              m_awlen;
  logic [2:0]              m_awsize;
  logic [1:0]              m_awburst;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [ID_BITS-1:0]      m_bid;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/dmac_write_burst.sv
// rtl/dmac_write_burst.sv - AXI4 INCR write engine splitting a transfer into 4KB-safe bursts; DMAC_WR_ERR_ABORT_EN stops after an erroring burst
module dmac_write_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int AWID_VAL   = 1,
  parameter int MAX_BURST  = 16,
  parameter int XFER_BITS  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [XFER_BITS-1:0]  beats_i,
  output logic                  busy_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  dmac_write_burst_if.master    bus,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_resp_o
);
  localparam int BPB  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPB - 1));

  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [XFER_BITS-1:0]  remaining;
  logic [8:0]            burst_n;
  logic [8:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  bready;
  logic                  done;
  logic                  err;
  logic [1:0]            err_resp;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [8:0]            next_n;
  logic                  in_w;
  logic                  w_hs;
  logic                  abort_hit;
  logic                  unused_bid;

  // Beats in the next burst: limited by what is left, the burst cap and the
  // room before the next 4KB page (address is always beat aligned, so room >= 1).
  function automatic logic [8:0] burst_len(input logic [11:0] page_off, input logic [XFER_BITS-1:0] rem);
    logic [12:0] room;
    logic [12:0] n;
    room = (13'd4096 - {1'b0, page_off}) >> SIZE;
    n = room;
    if (n > 13'(MAX_BURST)) n = 13'(MAX_BURST);
    if (32'(rem) < 32'(n)) n = 13'(rem);
    return 9'(n);
  endfunction

  assign start_addr = dst_addr_i & ALIGN_MASK;
  assign next_n     = (state == ST_IDLE) ? burst_len(start_addr[11:0], beats_i)
                                         : burst_len(addr[11:0], remaining);

`ifdef DMAC_WR_ERR_ABORT_EN
  assign abort_hit = (bus.m_bresp != 2'b00);
`else
  assign abort_hit = 1'b0;
`endif

  assign in_w = (state == ST_W);
  assign w_hs = bus.m_wvalid && bus.m_wready;

  assign busy_o         = (state != ST_IDLE);
  assign fifo_pop_o     = w_hs;
  assign done_o         = done;
  assign err_o          = err;
  assign err_resp_o     = err_resp;
  assign bus.m_awid     = awvalid ? ID_BITS'(AWID_VAL) : '0;
  assign bus.m_awaddr   = awaddr;
  assign bus.m_awlen    = awlen;
  assign bus.m_awsize   = awvalid ? 3'(SIZE) : 3'd0;
  assign bus.m_awburst  = awvalid ? 2'b01 : 2'b00;
  assign bus.m_awvalid  = awvalid;
  assign bus.m_wvalid   = in_w && !fifo_empty_i;
  assign bus.m_wdata    = in_w ? fifo_data_i : '0;
  assign bus.m_wstrb    = in_w ? '1 : '0;
  assign bus.m_wlast    = in_w && (beat_cnt == (burst_n - 9'd1));
  assign bus.m_bready   = bready;
  assign unused_bid     = ^bus.m_bid;

  // Transfer sequencer: one burst in flight, AW fields registered and held until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      burst_n   <= '0;
      beat_cnt  <= '0;
      awaddr    <= '0;
      awlen     <= '0;
      awvalid   <= 1'b0;
      bready    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_resp  <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            err      <= 1'b0;
            err_resp <= 2'b00;
            if (beats_i != '0) begin
              addr      <= start_addr;
              remaining <= beats_i;
              awaddr    <= start_addr;
              awlen     <= 8'(next_n - 9'd1);
              burst_n   <= next_n;
              awvalid   <= 1'b1;
              state     <= ST_AW;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_AW: begin
          if (bus.m_awready) begin
            awvalid   <= 1'b0;
            addr      <= addr + (ADDR_WIDTH'(burst_n) << SIZE);
            remaining <= remaining - XFER_BITS'(burst_n);
            beat_cnt  <= '0;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (bus.m_wlast) begin
              bready <= 1'b1;
              state  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (bus.m_bvalid) begin
            bready <= 1'b0;
            if (bus.m_bresp != 2'b00 && !err) begin
              err      <= 1'b1;
              err_resp <= bus.m_bresp;
            end
            if (remaining == '0 || abort_hit) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              awaddr  <= addr;
              awlen   <= 8'(next_n - 9'd1);
              burst_n <= next_n;
              awvalid <= 1'b1;
              state   <= ST_AW;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmac_write_burst.sv
// tb/tb_dmac_write_burst.sv - self-checking bench for dmac_write_burst against a burst-splitting reference model
module tb_dmac_write_burst;
  localparam int AW = 32, DW = 32, IDB = 4, MAXB = 16, XB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [31:0]   dst;
  logic [15:0]   beats;
  logic          busy;
  logic [31:0]   fdata;
  logic          fempty;
  logic          pop;
  logic          done;
  logic          err;
  logic [1:0]    err_resp;

  dmac_write_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_BITS(IDB)) bus();

  dmac_write_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_BITS(IDB), .AWID_VAL(1), .MAX_BURST(MAXB), .XFER_BITS(XB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dst_addr_i(dst), .beats_i(beats),
    .busy_o(busy), .fifo_data_i(fdata), .fifo_empty_i(fempty), .fifo_pop_o(pop),
    .bus(bus), .done_o(done), .err_o(err), .err_resp_o(err_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fifo_mem [256];
  int pop_idx = 0;

  // reference model output
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  // observed per transfer
  logic [31:0] got_addr[$];
  int          got_len[$];
  logic [8:0]  got_attr[$];
  int got_beats, data_bad, last_bad, empty_bad, pop_bad, stable_bad;
  int b_cnt, done_cnt, done_lat_bad, first_aw, busy_after, err_fin, resp_fin;

  // Expected bursts computed from the splitting rules with plain arithmetic.
  task automatic model(input logic [31:0] a0, input int nb, input int eb);
    int a, rem, room, n, k;
    exp_addr.delete();
    exp_len.delete();
    a = int'(a0 & ~32'h3);
    rem = nb;
    k = 0;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / (DW / 8);
      n = rem;
      if (n > MAXB) n = MAXB;
      if (n > room) n = room;
      exp_addr.push_back(32'(a));
      exp_len.push_back(n);
      a = a + n * (DW / 8);
      rem = rem - n;
`ifdef DMAC_WR_ERR_ABORT_EN
      if (k == eb) rem = 0;
`endif
      k++;
    end
  endtask

  task automatic idle_inputs();
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
    bus.m_bid     = '0;
    fempty        = 1'b1;
    fdata         = 32'h0;
  endtask

  // mode 0: no stalls, 1: random stalls, 2: fifo empty every other cycle + awready after 3 cycles
  task automatic run_xfer(input logic [31:0] a, input int nb, input int eb, input logic [1:0] ev,
                          input int mode, input int stop_after);
    int aw_wait, bdelay, beat_in, last_b_cyc, bi, cyc;
    logic prev_aw, pending_b;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    model(a, nb, eb);
    got_addr.delete(); got_len.delete(); got_attr.delete();
    got_beats = 0; data_bad = 0; last_bad = 0; empty_bad = 0; pop_bad = 0; stable_bad = 0;
    b_cnt = 0; done_cnt = 0; done_lat_bad = 0; first_aw = 0; busy_after = 1; err_fin = 0; resp_fin = 0;
    aw_wait = 0; bdelay = 0; beat_in = 0; prev_aw = 1'b0; pending_b = 1'b0;
    hold_addr = '0; hold_len = '0;
    last_b_cyc = (nb == 0) ? 0 : -10;
    @(negedge clk);
    idle_inputs();
    start = 1'b1; dst = a; beats = 16'(nb);
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 3000; cyc++) begin
      fempty = (mode == 2) ? cyc[0] : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      fdata  = fempty ? $urandom : fifo_mem[pop_idx % 256];
      bus.m_awready = (mode == 2) ? (aw_wait >= 3) : (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_wready  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_bvalid  = pending_b && (bdelay == 0);
      bus.m_bresp   = (b_cnt == eb) ? ev : 2'b00;
      #1;
      if (cyc == 1) first_aw = int'(bus.m_awvalid);
      if (bus.m_awvalid) begin
        if (prev_aw && (bus.m_awaddr !== hold_addr || bus.m_awlen !== hold_len)) stable_bad++;
        hold_addr = bus.m_awaddr; hold_len = bus.m_awlen; prev_aw = 1'b1;
        if (bus.m_awready) begin
          got_addr.push_back(bus.m_awaddr);
          got_len.push_back(int'(bus.m_awlen));
          got_attr.push_back({bus.m_awid, bus.m_awburst, bus.m_awsize});
          prev_aw = 1'b0; aw_wait = 0; beat_in = 0;
        end else aw_wait++;
      end
      if (pop !== (bus.m_wvalid && bus.m_wready)) pop_bad++;
      if (fempty && (bus.m_wvalid || pop)) empty_bad++;
      if (bus.m_wvalid && bus.m_wready) begin
        if (bus.m_wdata !== fifo_mem[pop_idx % 256]) data_bad++;
        if (bus.m_wstrb !== 4'hF) data_bad++;
        bi = got_len.size() - 1;
        if (bi < 0 || bi >= exp_len.size()) last_bad++;
        else if (bus.m_wlast !== (beat_in == exp_len[bi] - 1)) last_bad++;
        beat_in++; pop_idx++; got_beats++;
        if (bus.m_wlast) begin
          pending_b = 1'b1;
          bdelay = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
      end else if (pending_b && !bus.m_bvalid && bdelay > 0) bdelay--;
      if (bus.m_bvalid && bus.m_bready) begin
        b_cnt++; pending_b = 1'b0; last_b_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (cyc != last_b_cyc + 1) done_lat_bad++;
      end else if (done_cnt > 0) begin
        busy_after = int'(busy); err_fin = int'(err); resp_fin = int'(err_resp);
        break;
      end
      if (stop_after > 0 && got_beats >= stop_after) break;
      @(negedge clk);
    end
    if (stop_after == 0) idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dst = '0; beats = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, pop, done, err, err_resp, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready} !== 10'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {busy, pop, done, err, err_resp, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready}); end
    n_cmp++; if ({bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst, bus.m_awid} !== 49'd0) begin
      n_bad++; $display("FAIL reset_aw: got %h want 0", {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst, bus.m_awid}); end
    n_cmp++; if ({bus.m_wdata, bus.m_wstrb} !== 36'd0) begin
      n_bad++; $display("FAIL reset_w: got %h want 0", {bus.m_wdata, bus.m_wstrb}); end
  endtask

  task automatic test_single();
    run_xfer(32'h1000, 4, -1, 2'b00, 0, 0);
    n_cmp++; if (first_aw !== 1) begin n_bad++; $display("FAIL single_aw_latency: got %0d want 1", first_aw); end
    n_cmp++; if (got_addr.size() !== 1) begin n_bad++; $display("FAIL single_bursts: got %0d want 1", got_addr.size()); end
    else begin
      n_cmp++; if (got_addr[0] !== 32'h1000 || got_len[0] !== 3) begin
        n_bad++; $display("FAIL single_aw: got %h/%0d want 1000/3", got_addr[0], got_len[0]); end
      n_cmp++; if (got_attr[0] !== {4'd1, 2'b01, 3'd2}) begin
        n_bad++; $display("FAIL single_attr: got %b want %b", got_attr[0], {4'd1, 2'b01, 3'd2}); end
    end
    n_cmp++; if (got_beats !== 4 || data_bad !== 0 || last_bad !== 0 || pop_bad !== 0) begin
      n_bad++; $display("FAIL single_w: beats %0d data_bad %0d last_bad %0d pop_bad %0d want 4/0/0/0", got_beats, data_bad, last_bad, pop_bad); end
    n_cmp++; if (done_cnt !== 1 || done_lat_bad !== 0 || busy_after !== 0 || err_fin !== 0) begin
      n_bad++; $display("FAIL single_done: done %0d lat_bad %0d busy %0d err %0d want 1/0/0/0", done_cnt, done_lat_bad, busy_after, err_fin); end
  endtask

  task automatic test_split();
    logic [31:0] ea [3];
    int el [3];
    ea[0] = 32'h2000; ea[1] = 32'h2040; ea[2] = 32'h2080;
    el[0] = 15; el[1] = 15; el[2] = 7;
    run_xfer(32'h2000, 40, -1, 2'b00, 0, 0);
    n_cmp++; if (got_addr.size() !== 3) begin n_bad++; $display("FAIL split_bursts: got %0d want 3", got_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got_addr[i] !== ea[i] || got_len[i] !== el[i]) begin
        n_bad++; $display("FAIL split_aw%0d: got %h/%0d want %h/%0d", i, got_addr[i], got_len[i], ea[i], el[i]); end
    end
    n_cmp++; if (got_beats !== 40 || last_bad !== 0 || done_cnt !== 1) begin
      n_bad++; $display("FAIL split_w: beats %0d last_bad %0d done %0d want 40/0/1", got_beats, last_bad, done_cnt); end
  endtask

  task automatic test_boundary();
    run_xfer(32'h0FF8, 8, -1, 2'b00, 0, 0);
    n_cmp++; if (got_addr.size() !== 2) begin n_bad++; $display("FAIL bound_bursts: got %0d want 2", got_addr.size()); end
    else begin
      n_cmp++; if (got_addr[0] !== 32'h0FF8 || got_len[0] !== 1) begin
        n_bad++; $display("FAIL bound_aw0: got %h/%0d want ff8/1", got_addr[0], got_len[0]); end
      n_cmp++; if (got_addr[1] !== 32'h1000 || got_len[1] !== 5) begin
        n_bad++; $display("FAIL bound_aw1: got %h/%0d want 1000/5", got_addr[1], got_len[1]); end
    end
    n_cmp++; if (got_beats !== 8 || last_bad !== 0 || data_bad !== 0) begin
      n_bad++; $display("FAIL bound_w: beats %0d last_bad %0d data_bad %0d want 8/0/0", got_beats, last_bad, data_bad); end
  endtask

  task automatic test_backpressure();
    run_xfer(32'h3000, 20, -1, 2'b00, 2, 0);
    n_cmp++; if (stable_bad !== 0 || empty_bad !== 0 || pop_bad !== 0) begin
      n_bad++; $display("FAIL bp_rules: stable_bad %0d empty_bad %0d pop_bad %0d want 0/0/0", stable_bad, empty_bad, pop_bad); end
    n_cmp++; if (got_addr.size() !== 2 || got_beats !== 20 || last_bad !== 0 || data_bad !== 0) begin
      n_bad++; $display("FAIL bp_xfer: bursts %0d beats %0d last_bad %0d data_bad %0d want 2/20/0/0", got_addr.size(), got_beats, last_bad, data_bad); end
    n_cmp++; if (done_cnt !== 1 || done_lat_bad !== 0) begin
      n_bad++; $display("FAIL bp_done: done %0d lat_bad %0d want 1/0", done_cnt, done_lat_bad); end
  endtask

  task automatic test_error();
    int want_b;
`ifdef DMAC_WR_ERR_ABORT_EN
    want_b = 1;
`else
    want_b = 3;
`endif
    run_xfer(32'h4000, 48, 0, 2'b10, 0, 0);
    n_cmp++; if (got_addr.size() !== want_b || b_cnt !== want_b || got_beats !== 16 * want_b) begin
      n_bad++; $display("FAIL err_bursts: aw %0d b %0d beats %0d want %0d bursts", got_addr.size(), b_cnt, got_beats, want_b); end
    n_cmp++; if (done_cnt !== 1 || err_fin !== 1 || resp_fin !== 2) begin
      n_bad++; $display("FAIL err_status: done %0d err %0d resp %0d want 1/1/2", done_cnt, err_fin, resp_fin); end
    run_xfer(32'h4800, 4, -1, 2'b00, 0, 0);
    n_cmp++; if (err_fin !== 0 || resp_fin !== 0) begin
      n_bad++; $display("FAIL err_cleared: err %0d resp %0d want 0/0", err_fin, resp_fin); end
  endtask

  task automatic test_zero();
    run_xfer(32'h5000, 0, -1, 2'b00, 0, 0);
    n_cmp++; if (got_addr.size() !== 0 || got_beats !== 0 || first_aw !== 0) begin
      n_bad++; $display("FAIL zero_bus: aw %0d beats %0d awvalid %0d want 0/0/0", got_addr.size(), got_beats, first_aw); end
    n_cmp++; if (done_cnt !== 1 || done_lat_bad !== 0 || busy_after !== 0) begin
      n_bad++; $display("FAIL zero_done: done %0d lat_bad %0d busy %0d want 1/0/0", done_cnt, done_lat_bad, busy_after); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int nb, eb, tot, want_err;
    logic [1:0] ev;
    for (int it = 0; it < 10; it++) begin
      a  = {16'h0, 4'($urandom_range(0, 15)), 12'hF00 + 12'($urandom_range(0, 255))};
      nb = int'($urandom_range(1, 60));
      eb = int'($urandom_range(0, 3)) - 1;
      ev = 2'($urandom_range(1, 3));
      run_xfer(a, nb, eb, ev, 1, 0);
      tot = 0;
      foreach (exp_len[i]) tot += exp_len[i];
      want_err = (eb >= 0 && eb < exp_addr.size()) ? 1 : 0;
      n_cmp++; if (got_addr.size() !== exp_addr.size()) begin
        n_bad++; $display("FAIL rnd%0d_bursts: got %0d want %0d", it, got_addr.size(), exp_addr.size()); end
      else foreach (exp_addr[i]) begin
        n_cmp++; if (got_addr[i] !== exp_addr[i] || got_len[i] !== exp_len[i] - 1) begin
          n_bad++; $display("FAIL rnd%0d_aw%0d: got %h/%0d want %h/%0d", it, i, got_addr[i], got_len[i], exp_addr[i], exp_len[i] - 1); end
      end
      n_cmp++; if (got_beats !== tot || data_bad !== 0 || last_bad !== 0 || empty_bad !== 0 || pop_bad !== 0 || stable_bad !== 0) begin
        n_bad++; $display("FAIL rnd%0d_w: beats %0d/%0d data %0d last %0d empty %0d pop %0d stable %0d", it, got_beats, tot, data_bad, last_bad, empty_bad, pop_bad, stable_bad); end
      n_cmp++; if (done_cnt !== 1 || done_lat_bad !== 0 || err_fin !== want_err || resp_fin !== (want_err ? int'(ev) : 0)) begin
        n_bad++; $display("FAIL rnd%0d_done: done %0d lat_bad %0d err %0d resp %0d want 1/0/%0d/%0d", it, done_cnt, done_lat_bad, err_fin, resp_fin, want_err, want_err ? int'(ev) : 0); end
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(32'h6000, 4, -1, 2'b00, 0, 2);
    @(negedge clk);
    bus.m_wready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, pop, done, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready} !== 7'd0 || got_beats !== 2) begin
      n_bad++; $display("FAIL rstmid_outputs: got %b beats %0d want 0/2", {busy, pop, done, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready}, got_beats); end
    rst = 1'b0;
    idle_inputs();
    run_xfer(32'h6000, 4, -1, 2'b00, 0, 0);
    n_cmp++; if (got_addr.size() !== 1 || got_beats !== 4 || done_cnt !== 1 || last_bad !== 0) begin
      n_bad++; $display("FAIL rstmid_rerun: aw %0d beats %0d done %0d last_bad %0d want 1/4/1/0", got_addr.size(), got_beats, done_cnt, last_bad); end
    else begin
      n_cmp++; if (got_addr[0] !== 32'h6000 || got_len[0] !== 3) begin
        n_bad++; $display("FAIL rstmid_aw: got %h/%0d want 6000/3", got_addr[0], got_len[0]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fifo_mem[i] = $urandom;
    test_reset();
    test_single();
    test_split();
    test_boundary();
    test_backpressure();
    test_error();
    test_zero();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
